// File: rtl/ovl_multi_edge_pkg.sv
// Shared types and helpers for the multi-channel always-on-edge checker.
package ovl_multi_edge_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_POS  = 2'd1,
        EDGE_NEG  = 2'd2,
        EDGE_ANY  = 2'd3
    } edge_type_e;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ovl_edge_sample.sv
// One channel of sampling-event history and edge qualification.
module ovl_edge_sample
    import ovl_multi_edge_pkg::*;
#(
    parameter edge_type_e EDGE_TYPE = EDGE_POS
) (
    input  logic clock,
    input  logic reset,
    input  logic sample,
    input  logic prev_valid,
    output logic edge_det
);

    logic prev_q;
    logic prev_d;

    always_comb prev_d = sample;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= prev_d;
    end

    // Until one sample has been taken since reset, history is meaningless.
    always_comb begin
        edge_det = 1'b0;
        case (EDGE_TYPE)
            EDGE_NONE: edge_det = 1'b1;
            EDGE_POS:  edge_det = prev_valid & sample & ~prev_q;
            EDGE_NEG:  edge_det = prev_valid & ~sample & prev_q;
            EDGE_ANY:  edge_det = prev_valid & (sample ^ prev_q);
            default:   edge_det = 1'b0;
        endcase
    end

endmodule

// File: rtl/ovl_multi_always_on_edge.sv
// Multi-channel always-on-edge checker: per-channel failure pulse, sticky
// status, saturating counters, first-failure capture and post-reset hold-off.
module ovl_multi_always_on_edge
    import ovl_multi_edge_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned EDGE_TYPE = 1,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned HOLDOFF   = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [NUM_CH-1:0]             sampling_event,
    input  logic [NUM_CH*WIDTH-1:0]       test_expr,
    output logic [NUM_CH-1:0]             fire,
    output logic [NUM_CH-1:0]             fire_sticky,
    output logic [NUM_CH*CNT_W-1:0]       fail_count,
    output logic                          first_fail_valid,
    output logic [ch_idx_w(NUM_CH)-1:0]   first_fail_ch
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);
    localparam int unsigned HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam edge_type_e  EDGE_E = edge_type_e'(EDGE_TYPE[1:0]);

    logic                    prev_valid_q, prev_valid_d;
    logic [HO_W-1:0]         holdoff_q, holdoff_d;
    logic [NUM_CH-1:0]       fire_q, fire_d;
    logic [NUM_CH-1:0]       sticky_q, sticky_d;
    logic [NUM_CH*CNT_W-1:0] count_q, count_d;
    logic                    ffv_q, ffv_d;
    logic [CH_W-1:0]         ffc_q, ffc_d;

    logic [NUM_CH-1:0]       edge_det;
    logic [NUM_CH-1:0]       slice_zero;
    logic [NUM_CH-1:0]       fail;
    logic                    holdoff_done;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ovl_edge_sample #(
            .EDGE_TYPE(EDGE_E)
        ) u_edge (
            .clock      (clock),
            .reset      (reset),
            .sample     (sampling_event[c]),
            .prev_valid (prev_valid_q),
            .edge_det   (edge_det[c])
        );
        assign slice_zero[c] = ~|test_expr[c*WIDTH +: WIDTH];
    end

    assign holdoff_done = (holdoff_q == '0);
    assign fail = {NUM_CH{enable & holdoff_done}} & edge_det & slice_zero;

    // clear takes effect before this cycle's failures are folded in.
    always_comb begin
        prev_valid_d = 1'b1;
        holdoff_d    = holdoff_done ? holdoff_q : holdoff_q - HO_W'(1);
        fire_d       = fail;
        sticky_d     = (clear ? '0 : sticky_q) | fail;
        count_d      = clear ? '0 : count_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (fail[c]) begin
                count_d[c*CNT_W +: CNT_W] =
                    CNT_W'(sat_inc(32'(count_d[c*CNT_W +: CNT_W]), CNT_W));
            end
        end
        ffv_d = clear ? 1'b0 : ffv_q;
        ffc_d = clear ? '0 : ffc_q;
        if (!ffv_d && (|fail)) begin
            ffv_d = 1'b1;
            for (int unsigned c = NUM_CH; c > 0; c--) begin
                if (fail[c-1]) ffc_d = CH_W'(c - 1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_valid_q <= 1'b0;
            holdoff_q    <= HO_W'(HOLDOFF);
            fire_q       <= '0;
            sticky_q     <= '0;
            count_q      <= '0;
            ffv_q        <= 1'b0;
            ffc_q        <= '0;
        end else begin
            prev_valid_q <= prev_valid_d;
            holdoff_q    <= holdoff_d;
            fire_q       <= fire_d;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
            ffv_q        <= ffv_d;
            ffc_q        <= ffc_d;
        end
    end

    assign fire             = fire_q;
    assign fire_sticky      = sticky_q;
    assign fail_count       = count_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_ch    = ffc_q;

endmodule

// File: tb/tb_ovl_multi_always_on_edge.sv
// Bench: instances 0..3 use modes 0..3 (WIDTH=2, CNT_W=2, HOLDOFF=2);
// instance 4 uses defaults (WIDTH=1, posedge, CNT_W=8, HOLDOFF=0).
module tb_ovl_multi_always_on_edge;

    localparam int NI = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] se = '0;
    logic [7:0] te = '0;
    logic [3:0] te1 = '0;

    logic [3:0]  fire_a   [NI];
    logic [3:0]  sticky_a [NI];
    logic        ffv_a    [NI];
    logic [1:0]  ffc_a    [NI];
    logic [7:0]  fc_a     [4];
    logic [31:0] fc_b;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ovl_multi_always_on_edge #(
            .NUM_CH(4), .WIDTH(2), .EDGE_TYPE(g), .CNT_W(2), .HOLDOFF(2)
        ) u_dut (
            .clock(clock), .reset(reset), .enable(enable), .clear(clear),
            .sampling_event(se), .test_expr(te),
            .fire(fire_a[g]), .fire_sticky(sticky_a[g]), .fail_count(fc_a[g]),
            .first_fail_valid(ffv_a[g]), .first_fail_ch(ffc_a[g])
        );
    end

    ovl_multi_always_on_edge #(
        .NUM_CH(4), .WIDTH(1), .EDGE_TYPE(1), .CNT_W(8), .HOLDOFF(0)
    ) u_dflt (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .sampling_event(se), .test_expr(te1),
        .fire(fire_a[4]), .fire_sticky(sticky_a[4]), .fail_count(fc_b),
        .first_fail_valid(ffv_a[4]), .first_fail_ch(ffc_a[4])
    );

    // Reference model: per-instance cycle count since reset, counts as ints.
    bit [3:0] m_prev   [NI];
    int       m_k      [NI];
    int       m_cnt    [NI][4];
    bit [3:0] m_sticky [NI];
    bit [3:0] m_fire   [NI];
    bit       m_ffv    [NI];
    int       m_ffc    [NI];

    function automatic int mode_of(int i); return (i < 4) ? i : 1;   endfunction
    function automatic int cmax_of(int i); return (i < 4) ? 3 : 255; endfunction
    function automatic int ho_of(int i);   return (i < 4) ? 2 : 0;   endfunction
    function automatic int cw_of(int i);   return (i < 4) ? 2 : 8;   endfunction

    function automatic bit slice_zero(int i, int c);
        if (i < 4) return te[2*c +: 2] == 2'b00;
        return te1[c] == 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_prev[i] = '0; m_k[i] = 0; m_sticky[i] = '0; m_fire[i] = '0;
            m_ffv[i] = 1'b0; m_ffc[i] = 0;
            for (int c = 0; c < 4; c++) m_cnt[i][c] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            bit [3:0] f;
            f = '0;
            for (int c = 0; c < 4; c++) begin
                bit s, p, e;
                s = se[c]; p = m_prev[i][c];
                case (mode_of(i))
                    0:       e = 1'b1;
                    1:       e = (m_k[i] > 0) && s && !p;
                    2:       e = (m_k[i] > 0) && !s && p;
                    default: e = (m_k[i] > 0) && (s != p);
                endcase
                f[c] = enable && (m_k[i] >= ho_of(i)) && e && slice_zero(i, c);
            end
            if (clear) begin
                for (int c = 0; c < 4; c++) m_cnt[i][c] = 0;
                m_sticky[i] = '0; m_ffv[i] = 1'b0; m_ffc[i] = 0;
            end
            for (int c = 0; c < 4; c++)
                if (f[c] && m_cnt[i][c] < cmax_of(i)) m_cnt[i][c]++;
            m_sticky[i] |= f;
            m_fire[i] = f;
            if (!m_ffv[i] && f != 0) begin
                m_ffv[i] = 1'b1;
                for (int c = 3; c >= 0; c--) if (f[c]) m_ffc[i] = c;
            end
            m_prev[i] = se;
            if (m_k[i] < 1000) m_k[i]++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            logic [31:0] ecnt, acnt;
            ecnt = '0;
            for (int c = 0; c < 4; c++) ecnt |= 32'(m_cnt[i][c]) << (c * cw_of(i));
            acnt = (i < 4) ? {24'd0, fc_a[i]} : fc_b;
            chk($sformatf("fire[%0d]", i),   {28'd0, fire_a[i]},   {28'd0, m_fire[i]});
            chk($sformatf("sticky[%0d]", i), {28'd0, sticky_a[i]}, {28'd0, m_sticky[i]});
            chk($sformatf("count[%0d]", i),  acnt, ecnt);
            chk($sformatf("ffv[%0d]", i),    {31'd0, ffv_a[i]},    {31'd0, m_ffv[i]});
            chk($sformatf("ffch[%0d]", i),   {30'd0, ffc_a[i]},    32'(m_ffc[i]));
        end
    endtask

    task automatic do_cycle();
        @(posedge clock);
        if (reset) model_reset();
        else       model_step();
        #1;
        check_all();
    endtask

    function automatic logic [3:0] nz_map(input logic [7:0] t);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = |t[2*c +: 2];
        return r;
    endfunction

    typedef struct {
        bit       en;
        bit       clr;
        bit [3:0] se;
        bit [7:0] te;
        bit [3:0] exp1;
    } vec_t;

    vec_t tbl[10];
    int   pulses[NI];

    initial begin
        tbl[0] = '{1, 0, 4'b0001, 8'hFC, 4'b0001};
        tbl[1] = '{1, 0, 4'b0000, 8'hFF, 4'b0000};
        tbl[2] = '{1, 0, 4'b1110, 8'h23, 4'b1010};
        tbl[3] = '{1, 0, 4'b0000, 8'h00, 4'b0000};
        tbl[4] = '{1, 0, 4'b0100, 8'h00, 4'b0100};
        tbl[5] = '{1, 0, 4'b0000, 8'h00, 4'b0000};
        tbl[6] = '{0, 0, 4'b0100, 8'h00, 4'b0000};
        tbl[7] = '{1, 0, 4'b0100, 8'h00, 4'b0000};
        tbl[8] = '{1, 0, 4'b0000, 8'h00, 4'b0000};
        tbl[9] = '{1, 1, 4'b0100, 8'h00, 4'b0100};

        model_reset();
        #1;
        check_all();
        do_cycle();
        do_cycle();
        reset = 1'b0;

        enable = 1'b1; se = '0; te = 8'hFF; te1 = 4'hF;
        for (int n = 0; n < 3; n++) do_cycle();

        foreach (tbl[v]) begin
            enable = tbl[v].en; clear = tbl[v].clr; se = tbl[v].se;
            te = tbl[v].te; te1 = nz_map(tbl[v].te);
            do_cycle();
            chk($sformatf("tbl%0d_fire1", v), {28'd0, fire_a[1]}, {28'd0, tbl[v].exp1});
        end
        clear = 1'b0;
        chk("tbl_count1", {24'd0, fc_a[1]}, 32'h10);
        chk("tbl_ffch1", {30'd0, ffc_a[1]}, 32'd2);

        // Saturation on a 2-bit counter, then clear coinciding with a failure.
        te = 8'h00; te1 = 4'h0;
        for (int n = 0; n < 5; n++) begin
            se = 4'b0100; do_cycle();
            se = 4'b0000; do_cycle();
        end
        chk("sat_count1", {30'd0, fc_a[1][5:4]}, 32'd3);
        se = 4'b0100; clear = 1'b1;
        do_cycle();
        clear = 1'b0;
        chk("clrfail_count1", {24'd0, fc_a[1]}, 32'h10);
        chk("clrfail_sticky1", {28'd0, sticky_a[1]}, 32'b0100);
        chk("clrfail_ffch1", {30'd0, ffc_a[1]}, 32'd2);
        se = 4'b0000; do_cycle();

        // ch0 pulse 0->1->0 against every edge mode.
        te = 8'hFC; te1 = 4'b1110;
        foreach (pulses[i]) pulses[i] = 0;
        for (int n = 0; n < 5; n++) begin
            se = (n == 1) ? 4'b0001 : 4'b0000;
            do_cycle();
            for (int i = 0; i < NI; i++) pulses[i] += int'(fire_a[i][0]);
        end
        chk("pulses_none", pulses[0], 5);
        chk("pulses_pos",  pulses[1], 1);
        chk("pulses_neg",  pulses[2], 1);
        chk("pulses_any",  pulses[3], 2);
        chk("pulses_dflt", pulses[4], 1);

        // Reset mid-run with the sampling event held high.
        se = 4'b1111; te = 8'h00; te1 = 4'h0;
        do_cycle();
        reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_fire[%0d]", i),   {28'd0, fire_a[i]},   32'd0);
            chk($sformatf("rst_sticky[%0d]", i), {28'd0, sticky_a[i]}, 32'd0);
            chk($sformatf("rst_ffv[%0d]", i),    {31'd0, ffv_a[i]},    32'd0);
        end
        check_all();
        do_cycle();
        reset = 1'b0;
        do_cycle();
        chk("ho_e1_none", {28'd0, fire_a[0]}, 32'd0);
        chk("ho_e1_dflt", {28'd0, fire_a[4]}, 32'd0);
        do_cycle();
        chk("ho_e2_none", {28'd0, fire_a[0]}, 32'd0);
        se = 4'b0000;
        do_cycle();
        chk("ho_e3_none", {28'd0, fire_a[0]}, 32'hF);
        chk("ho_e3_pos",  {28'd0, fire_a[1]}, 32'd0);
        chk("ho_e3_any",  {28'd0, fire_a[3]}, 32'hF);
        se = 4'b1111;
        do_cycle();
        chk("ho_e4_pos",  {28'd0, fire_a[1]}, 32'hF);
        chk("ho_e4_dflt", {28'd0, fire_a[4]}, 32'hF);

        // Randomized run against the model, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_all();
                do_cycle();
                reset = 1'b0;
            end
            enable = ($urandom_range(0, 7) != 0);
            clear  = ($urandom_range(0, 15) == 0);
            se     = 4'($urandom);
            te     = 8'($urandom & $urandom);
            te1    = 4'($urandom & $urandom);
            do_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ovl_multi_always_on_edge.md
Name: ovl_multi_always_on_edge

Overview:
Multi-channel, parametrised successor to the single-channel always-on-edge checker used by the OVL semantic wrappers. Each channel samples a WIDTH-bit test expression when its sampling event shows the configured edge. A channel fails when that expression is all-zero at the sampling point. Adds per-channel saturating failure counters, sticky status, first-failure capture, a post-reset hold-off window and a clear input. It sits under ovl_sem_* wrappers and the formal/sim regression harness.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
WIDTH, 1, bits of test_expr per channel; a sample passes when that channel's slice is non-zero
EDGE_TYPE, 1, 0=none (check every enabled cycle), 1=posedge, 2=negedge, 3=any edge of sampling_event
CNT_W, 8, width of each per-channel failure counter (saturating)
HOLDOFF, 0, clock cycles after reset release during which no check is performed

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  global check enable
clear  in  1  synchronous pulse; clears counters, sticky bits and first-failure capture
sampling_event  in  NUM_CH  per-channel sampling signal
test_expr  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
fire  out  NUM_CH  registered one-cycle failure pulse per channel
fire_sticky  out  NUM_CH  set on failure, held until clear or reset
fail_count  out  NUM_CH*CNT_W  channel c at [c*CNT_W +: CNT_W]
first_fail_valid  out  1  a first failure has been captured
first_fail_ch  out  max(1,$clog2(NUM_CH))  index of the first failing channel

Behaviour:
- Reset (async assert, sync release): all outputs 0; prev-sample regs 0; prev_valid 0; hold-off counter = HOLDOFF.
- Edge detect per channel: prev[c] <= sampling_event[c] every clock, regardless of enable. prev_valid becomes 1 after the first clock edge following reset release.
- With prev_valid=0, no edge is detected in modes 1-3, so a level held high across reset does not produce a spurious posedge. Mode 0 ignores prev_valid.
- check[c] = enable & holdoff_done & edge[c]:
  - mode 0: edge = 1
  - mode 1: edge = s & ~prev
  - mode 2: edge = ~s & prev
  - mode 3: edge = s ^ prev
- holdoff_done = (holdoff counter == 0). The counter decrements once per clock after reset and stops at 0. HOLDOFF=0 means checks start immediately, still subject to prev_valid.
- fail[c] = check[c] & (slice c == 0).
- fire[c] is registered from fail[c]: high exactly one cycle after the clock edge where the failure is sampled. Latency is 1.
- fail_count[c] increments on fail[c] and saturates at 2^CNT_W-1; no wrap.
- fire_sticky[c] is set on fail[c].
- First failure: if first_fail_valid=0 and any fail, capture the lowest failing index and set valid. Later failures do not overwrite the capture.
- clear vs. failure in the same cycle: clear applies first, then the failure. Result: count=1, sticky=1, first-failure recaptured from that cycle.
- clear does not affect fire, prev or the hold-off counter.
- Reset mid-operation returns everything to reset state immediately (asynchronously); hold-off restarts on release.
- enable=0: no checks, no fire, counters frozen; edge history keeps tracking.

Decomposition:
- Package ovl_multi_edge_pkg:
  - edge_type_e enum (EDGE_NONE=0, EDGE_POS=1, EDGE_NEG=2, EDGE_ANY=3)
  - saturating-increment function
  - ch_idx_w(NUM_CH) width helper
- One natural sub-module, ovl_edge_sample: per channel, holds prev and produces edge. Instantiated NUM_CH times with generate.
- Counter, sticky and first-failure logic live in the top.

Test Plan:
- NUM_CH=4, WIDTH=1, posedge: ch0 sampling_event high only in cycle 1, test_expr[0]=0 that cycle -> fire=4'b0001 in cycle 2 only; fail_count[0]=1; first_fail_valid=1; first_fail_ch=0.
- Same stimulus with test_expr all-ones -> fire, sticky and counts stay 0 for 20 cycles.
- WIDTH=2: ch1 and ch3 rise together with slices 2'b00, ch2 rises with 2'b10 -> fire=4'b1010 next cycle; first_fail_ch=1; sticky=4'b1010.
- CNT_W=2: ch2 fails on 5 separate rising edges -> fail_count[2]=3 and stays 3. Then clear pulsed in the cycle of a 6th failure -> count=1, sticky[2]=1, first_fail_ch=2.
- Negedge and any-edge modes: ch0 toggles 0->1->0 with test_expr=0 -> mode 2 fires once (on the fall); mode 3 fires twice; mode 0 fires every enabled cycle.
- sampling_event held high, reset asserted mid-run, HOLDOFF=2 -> all outputs 0 immediately. After release, no fire on first sample; failures are ignored for 2 cycles; the first genuine posedge after that fires.
